// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings for the fetch stage
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_DRAIN  = 2'd1,
    FS_HALTED = 2'd2
  } fs_state_e;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_ENC    = 32'h0000_0013;
  localparam logic [31:0] BAD_ENC    = 32'hbadb_adff;

  function automatic logic is_system(input logic [31:0] inst);
    return inst[6:0] == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// rtl/fetch_stage_sat_counter.sv - saturating up counter
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generation and IF/ID register with stall, redirect and halt drain
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0100_0000,
  parameter logic [31:0]      NOP_INST     = NOP_ENC,
  parameter logic [31:0]      BAD_INST     = BAD_ENC,
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall_d,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  pc_d,
  output logic [31:0]      inst_d,
  output logic             valid_d,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fs_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_dec_q, pc_dec_d;
  logic [31:0]     inst_q, inst_d_n;
  logic            valid_q, valid_d_n;
  logic            err_pend_q, err_pend_d;
  logic            fetch_err_q, fetch_err_d;
  logic            stall_inc, flush_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_RUN;
      pc_f_q      <= RESET_VECTOR;
      pc_dec_q    <= '0;
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      pc_dec_q    <= pc_dec_d;
      inst_q      <= inst_d_n;
      valid_q     <= valid_d_n;
      err_pend_q  <= err_pend_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_dec_d    = pc_dec_q;
    inst_d_n    = inst_q;
    valid_d_n   = valid_q;
    err_pend_d  = err_pend_q;
    fetch_err_d = fetch_err_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (state_q != FS_HALTED) begin
      if (redirect) begin
        // Masking rather than slicing keeps the target word-aligned and every bit in use.
        pc_f_d     = redirect_pc & ~XLEN'(3);
        inst_d_n   = NOP_INST;
        valid_d_n  = 1'b0;
        state_d    = FS_RUN;
        err_pend_d = 1'b0;
        flush_inc  = 1'b1;
      end else if (stall_d) begin
        stall_inc = 1'b1;
      end else if (state_q == FS_RUN) begin
        if (imem_rdata == BAD_INST) begin
          inst_d_n   = NOP_INST;
          valid_d_n  = 1'b0;
          err_pend_d = 1'b1;
          state_d    = FS_DRAIN;
        end else begin
          pc_dec_d  = pc_f_q;
          inst_d_n  = imem_rdata;
          valid_d_n = 1'b1;
          if (is_system(imem_rdata)) begin
            state_d = FS_DRAIN;
          end else begin
            pc_f_d = pc_f_q + XLEN'(4);
          end
        end
      end else begin
        inst_d_n    = NOP_INST;
        valid_d_n   = 1'b0;
        state_d     = FS_HALTED;
        fetch_err_d = err_pend_q;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign imem_addr = pc_f_q;
  assign pc_d      = pc_dec_q;
  assign inst_d    = inst_q;
  assign valid_d   = valid_q;
  assign halted    = (state_q == FS_HALTED);
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] RV   = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BAD  = 32'hbadb_adff;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   imem_addr, imem_rdata, redirect_pc, pc_d, inst_d;
  logic          stall_d, redirect, valid_d, halted, fetch_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  fetch_stage #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_d        (pc_d),
    .inst_d      (inst_d),
    .valid_d     (valid_d),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mode 0 = fetching, 1 = last fetch was halt-class, 2 = stopped
  logic [31:0] m_pc_f, m_pc_d, m_inst;
  logic        m_valid, m_pend, m_err;
  int          m_mode, m_stall, m_flush;

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model_reset();
    m_pc_f = RV; m_pc_d = 0; m_inst = NOP; m_valid = 0;
    m_pend = 0; m_err = 0; m_mode = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    if (m_mode == 2) return;
    if (redirect) begin
      m_pc_f  = (redirect_pc / 4) * 4;
      m_inst  = NOP; m_valid = 0; m_mode = 0; m_pend = 0;
      m_flush = sat(m_flush);
    end else if (stall_d) begin
      m_stall = sat(m_stall);
    end else if (m_mode == 0) begin
      if (imem_rdata == BAD) begin
        m_inst = NOP; m_valid = 0; m_pend = 1; m_mode = 1;
      end else begin
        m_pc_d = m_pc_f; m_inst = imem_rdata; m_valid = 1;
        if (imem_rdata % 128 == 32'h73) m_mode = 1;
        else m_pc_f = m_pc_f + 4;
      end
    end else begin
      m_inst = NOP; m_valid = 0; m_mode = 2; m_err = m_pend;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc_f);
    chk("pc_d", pc_d, m_pc_d);
    chk("inst_d", inst_d, m_inst);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    chk("halted", {31'b0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    chk("stall_cnt", {28'b0, stall_cnt}, m_stall);
    chk("flush_cnt", {28'b0, flush_cnt}, m_flush);
  endtask

  function automatic logic [31:0] addi_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'b0010011;
    return w;
  endfunction

  task automatic set_in(input logic s, input logic r, input logic [31:0] rpc, input logic [31:0] rd);
    stall_d = s; redirect = r; redirect_pc = rpc; imem_rdata = rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, NOP);
    #1;
    model_reset();
    check_all();
    chk("rst_addr", imem_addr, RV);
    @(negedge clk);
    reset = 1'b0;

    repeat (2) begin set_in(0, 0, 0, addi_word()); cycle(); end
    chk("seq_addr", imem_addr, 32'h0100_0008);
    chk("seq_pc_d", pc_d, 32'h0100_0004);
    repeat (3) begin set_in(1, 0, 0, addi_word()); cycle(); end
    chk("stall3", {28'b0, stall_cnt}, 32'd3);
    set_in(0, 0, 0, addi_word()); cycle();
    chk("resume", imem_addr, 32'h0100_000c);

    set_in(1, 1, 32'h0100_0042, addi_word()); cycle();
    chk("redir_addr", imem_addr, 32'h0100_0040);
    chk("redir_flush", {28'b0, flush_cnt}, 32'd1);

    set_in(0, 1, 32'h0100_0010, addi_word()); cycle();
    set_in(0, 0, 0, ECALL); cycle();
    set_in(0, 1, 32'h0100_0100, addi_word()); cycle();
    chk("drain_redir", imem_addr, 32'h0100_0100);
    set_in(0, 0, 0, addi_word()); cycle();
    chk("drain_resume", imem_addr, 32'h0100_0104);

    set_in(0, 0, 0, ECALL); cycle();
    chk("ecall_inst", inst_d, ECALL);
    set_in(0, 0, 0, addi_word()); cycle();
    chk("ecall_halt", {31'b0, halted}, 32'd1);
    set_in(1, 1, 32'h0200_0000, addi_word()); cycle();
    set_in(0, 1, 32'h0200_0000, addi_word()); cycle();
    chk("halt_sticky", imem_addr, 32'h0100_0104);

    do_reset();
    set_in(0, 0, 0, BAD); cycle();
    set_in(0, 0, 0, addi_word()); cycle();
    chk("bad_err", {31'b0, fetch_err}, 32'd1);

    do_reset();
    set_in(0, 0, 0, BAD); cycle();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_rst", imem_addr, RV);
    @(negedge clk);
    reset = 1'b0;

    set_in(0, 1, 32'hffff_fffb, addi_word()); cycle();
    repeat (2) begin set_in(0, 0, 0, addi_word()); cycle(); end
    chk("wrap", imem_addr, 32'h0000_0000);
    repeat (20) begin set_in(1, 0, 0, addi_word()); cycle(); end
    chk("stall_sat", {28'b0, stall_cnt}, CMAX);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] rd, rpc;
      int sel;
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      sel = $urandom_range(0, 99);
      rd = (sel < 3) ? ECALL : (sel < 5) ? BAD : addi_word();
      rpc = ($urandom_range(0, 9) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf)) : $urandom;
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rpc, rd);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
